// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue_if
// Brief    : Fetch request/response, redirect and decode-side handshake
//            signals of the instruction fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_misalign;

  // master is the fetch queue itself; slave is memory/decode/branch side
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, fetch_misalign,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, fetch_misalign,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           out_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Brief    : Sequential instruction fetcher with in-order responses buffered in
//            a DEPTH-entry {pc, instr} FIFO; redirect flushes queue and fetches.
//            Optional macro IFQ_ALIGN_CHK_EN halts fetch on misaligned redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_queue_if.master bus
);

  localparam int unsigned    CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned    PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]        pc_mem_q    [DEPTH];
  logic [31:0]        instr_mem_q [DEPTH];
`ifdef IFQ_ALIGN_CHK_EN
  logic               misalign_q, misalign_d;
`endif

  logic [CNT_W:0]     occupancy;
  logic [31:0]        redirect_target;
  logic               req_valid;
  logic               req_fire;
  logic               resp_fire;
  logic               out_valid;
  logic               pop;
  logic               push;

  always_comb begin
    occupancy = {1'b0, count_q} + {1'b0, outstanding_q};
`ifdef IFQ_ALIGN_CHK_EN
    redirect_target = bus.redirect_pc;
`else
    redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
`endif
    // Buffered plus in-flight entries never exceed DEPTH, so a push can't overflow
    req_valid = !reset && (state_q == ST_FETCH) && !bus.redirect_valid &&
                (occupancy < DEPTH_W);
    req_fire  = req_valid && bus.imem_req_ready;
    resp_fire = bus.imem_resp_valid;
    out_valid = (count_q != '0) && !bus.redirect_valid;
    pop       = out_valid && bus.out_ready;
    push      = resp_fire && (drop_cnt_q == '0) && !bus.redirect_valid;
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
`ifdef IFQ_ALIGN_CHK_EN
    misalign_d    = misalign_q;
`endif

    if (bus.redirect_valid) begin
      // Everything still owed by memory (minus the one arriving now) is stale
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = outstanding_q - CNT_W'(resp_fire);
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
`ifdef IFQ_ALIGN_CHK_EN
      if (redirect_target[1:0] != 2'b00) begin
        state_d    = ST_HALT;
        misalign_d = 1'b1;
      end else begin
        state_d    = ST_FETCH;
        misalign_d = 1'b0;
      end
`endif
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
`ifdef IFQ_ALIGN_CHK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
`ifdef IFQ_ALIGN_CHK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  // Storage is cleared on reset so the head outputs read zero out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
      instr_mem_q[wr_ptr_q] <= bus.imem_resp_data;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = pc_mem_q[rd_ptr_q];
  assign bus.out_instr      = instr_mem_q[rd_ptr_q];
`ifdef IFQ_ALIGN_CHK_EN
  assign bus.fetch_misalign = misalign_q;
`else
  assign bus.fetch_misalign = 1'b0;
`endif

  a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
    bus.imem_resp_valid |-> (outstanding_q != '0));
  a_drop_bounded: assert property (@(posedge clk) disable iff (reset)
    drop_cnt_q <= outstanding_q);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Brief    : Randomised self-checking bench with an in-order memory model and
//            a program-order expectation of the {pc, instr} stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic        ov;
    logic        pop;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rv;
    logic        rrdy;
    logic [31:0] raddr;
    logic        mis;
  } obs_t;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic clk;
  logic reset;
  instr_fetch_queue_if bus ();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  int          rdy_pct  = 100;
  pend_t       mq[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] exp_pc;

  // Every address holds a distinct word, so stale or shifted data is visible
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: accepts on valid&ready, answers in order after lat cycles
  initial begin
    int l;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        mq.delete();
      end else begin
        if (bus.imem_resp_valid && mq.size() > 0) void'(mq.pop_front());
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          l = int'($urandom_range(lat_max, lat_min));
          mq.push_back('{addr: bus.imem_req_addr, due: cyc + l - 1});
          req_log.push_back(bus.imem_req_addr);
          req_cyc.push_back(cyc);
        end
      end
      #1;
      bus.imem_req_ready = (int'($urandom_range(99, 0)) < rdy_pct);
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = instr_of(mq[0].addr);
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = $urandom;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle: drive at the falling edge, sample 1 ns later, return at next falling edge
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc, output obs_t o);
    bus.out_ready      = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    o.ov    = bus.out_valid;
    o.pop   = bus.out_valid && rdy;
    o.pc    = bus.out_pc;
    o.instr = bus.out_instr;
    o.rv    = bus.imem_req_valid;
    o.rrdy  = bus.imem_req_ready;
    o.raddr = bus.imem_req_addr;
    o.mis   = bus.fetch_misalign;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset              = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req_log.delete();
    req_cyc.delete();
    exp_pc = RESET_PC;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
    n_checks++; if (bus.imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h expected %h", bus.imem_req_addr, RESET_PC); end
    n_checks++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", bus.out_pc); end
    n_checks++; if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h expected 0", bus.out_instr); end
    n_checks++; if (bus.fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", bus.fetch_misalign); end
  endtask

  task automatic test_stream();
    obs_t o; int npops = 0; int first = -1;
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, '0, o);
      if (o.pop) begin
        if (first < 0) first = i;
        npops++;
        n_checks++; if (o.pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc: got %h expected %h", o.pc, exp_pc); end
        n_checks++; if (o.instr !== instr_of(exp_pc)) begin n_fail++; $display("FAIL stream_instr: got %h expected %h", o.instr, instr_of(exp_pc)); end
        exp_pc += 32'd4;
      end
    end
    n_checks++; if (first != 2) begin n_fail++; $display("FAIL stream_first_pop_cycle: got %0d expected 2", first); end
    n_checks++; if (npops != 18) begin n_fail++; $display("FAIL stream_pop_count: got %0d expected 18", npops); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (req_log.size() <= i || req_log[i] !== 32'(4 * i) || req_cyc[i] != req_cyc[0] + i) begin
        n_fail++; $display("FAIL stream_req_seq[%0d]: got %h expected %h on consecutive cycles", i,
                           (req_log.size() > i) ? req_log[i] : 32'hxxxx_xxxx, 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    apply_reset();
    repeat (12) step(1'b0, 1'b0, '0, o);
    n_checks++; if (req_log.size() != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 4", req_log.size()); end
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      n_checks++; if (req_log[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL bp_req_addr[%0d]: got %h expected %h", i, req_log[i], 32'(4 * i)); end
    end
    n_checks++; if (o.rv !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid_full: got %b expected 0", o.rv); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0, o);
      n_checks++; if (o.pop !== 1'b1 || o.pc !== exp_pc) begin n_fail++; $display("FAIL bp_drain[%0d]: got pop=%b pc=%h expected pop=1 pc=%h", i, o.pop, o.pc, exp_pc); end
      exp_pc += 32'd4;
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, '0, o);
      if (o.pop) begin
        n_checks++; if (o.pc !== exp_pc || o.instr !== instr_of(exp_pc)) begin n_fail++; $display("FAIL bp_resume: got pc=%h instr=%h expected pc=%h instr=%h", o.pc, o.instr, exp_pc, instr_of(exp_pc)); end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_redirect_inflight();
    obs_t o; int mark; int npops = 0;
    lat_min = 4; lat_max = 4; rdy_pct = 100;
    apply_reset();
    for (int i = 0; i < 10 && mq.size() < 2; i++) step(1'b1, 1'b0, '0, o);
    n_checks++; if (mq.size() != 2) begin n_fail++; $display("FAIL inflight_setup: got %0d in flight expected 2", mq.size()); end
    step(1'b1, 1'b1, 32'h100, o);
    n_checks++; if (o.ov !== 1'b0 || o.rv !== 1'b0) begin n_fail++; $display("FAIL inflight_redirect_cycle: got ov=%b rv=%b expected 0 0", o.ov, o.rv); end
    exp_pc = 32'h100;
    mark   = req_log.size();
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, '0, o);
      if (o.pop) begin
        npops++;
        n_checks++; if (o.pc !== exp_pc || o.instr !== instr_of(exp_pc)) begin n_fail++; $display("FAIL inflight_stream: got pc=%h instr=%h expected pc=%h instr=%h", o.pc, o.instr, exp_pc, instr_of(exp_pc)); end
        exp_pc += 32'd4;
      end
    end
    n_checks++; if (npops < 5) begin n_fail++; $display("FAIL inflight_pops: got %0d expected >=5", npops); end
    n_checks++; if (req_log.size() <= mark || req_log[mark] !== 32'h100) begin n_fail++; $display("FAIL inflight_restart_addr: got %0d entries expected first=00000100", req_log.size() - mark); end
  endtask

  task automatic test_redirect_collide();
    obs_t o; int npops = 0; logic hit = 1'b0;
    lat_min = 2; lat_max = 2; rdy_pct = 100;
    apply_reset();
    for (int i = 0; i < 40 && !hit; i++) begin
      if (bus.imem_resp_valid && bus.out_valid) hit = 1'b1;
      else step(1'b0, 1'b0, '0, o);
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL collide_setup: got no response/valid overlap expected one"); end
    step(1'b1, 1'b1, 32'h300, o);
    n_checks++; if (o.ov !== 1'b0 || o.pop !== 1'b0) begin n_fail++; $display("FAIL collide_no_pop: got ov=%b pop=%b expected 0 0", o.ov, o.pop); end
    exp_pc = 32'h300;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, '0, o);
      if (o.pop) begin
        npops++;
        n_checks++; if (o.pc !== exp_pc || o.instr !== instr_of(exp_pc)) begin n_fail++; $display("FAIL collide_stream: got pc=%h instr=%h expected pc=%h instr=%h", o.pc, o.instr, exp_pc, instr_of(exp_pc)); end
        exp_pc += 32'd4;
      end
    end
    n_checks++; if (npops < 5) begin n_fail++; $display("FAIL collide_pops: got %0d expected >=5", npops); end
  endtask

  task automatic test_reset_mid();
    obs_t o; int npops = 0;
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    apply_reset();
    for (int i = 0; i < 10 && req_log.size() < 3; i++) begin
      if (req_log.size() >= 2) rdy_pct = 0;
      step(1'b0, 1'b0, '0, o);
    end
    repeat (4) step(1'b0, 1'b0, '0, o);
    n_checks++; if (req_log.size() != 3 || o.ov !== 1'b1) begin n_fail++; $display("FAIL midreset_setup: got reqs=%0d ov=%b expected 3 1", req_log.size(), o.ov); end
    rdy_pct = 100;
    reset   = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL midreset_req_addr: got %h expected %h", bus.imem_req_addr, RESET_PC); end
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_req_valid: got %b expected 0", bus.imem_req_valid); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req_log.delete(); req_cyc.delete();
    exp_pc = RESET_PC;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, '0, o);
      if (o.pop) begin
        npops++;
        n_checks++; if (o.pc !== exp_pc || o.instr !== instr_of(exp_pc)) begin n_fail++; $display("FAIL midreset_restart: got pc=%h instr=%h expected pc=%h instr=%h", o.pc, o.instr, exp_pc, instr_of(exp_pc)); end
        exp_pc += 32'd4;
      end
    end
    n_checks++; if (npops < 5) begin n_fail++; $display("FAIL midreset_pops: got %0d expected >=5", npops); end
  endtask

  task automatic test_misalign();
    obs_t o; int mark; logic any;
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    apply_reset();
    repeat (5) step(1'b1, 1'b0, '0, o);
`ifdef IFQ_ALIGN_CHK_EN
    step(1'b1, 1'b1, 32'h102, o);
    mark = req_log.size();
    any  = 1'b0;
    repeat (8) begin
      step(1'b1, 1'b0, '0, o);
      if (o.rv || o.ov) any = 1'b1;
    end
    n_checks++; if (any !== 1'b0 || req_log.size() != mark) begin n_fail++; $display("FAIL halt_activity: got active=%b reqs=%0d expected 0 0", any, req_log.size() - mark); end
    n_checks++; if (o.mis !== 1'b1) begin n_fail++; $display("FAIL halt_misalign_set: got %b expected 1", o.mis); end
    step(1'b1, 1'b1, 32'h200, o);
    exp_pc = 32'h200;
`else
    step(1'b1, 1'b1, 32'h102, o);
    exp_pc = 32'h100;
`endif
    mark = req_log.size();
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, '0, o);
      if (o.pop) begin
        n_checks++; if (o.pc !== exp_pc || o.instr !== instr_of(exp_pc)) begin n_fail++; $display("FAIL misalign_stream: got pc=%h instr=%h expected pc=%h instr=%h", o.pc, o.instr, exp_pc, instr_of(exp_pc)); end
        exp_pc += 32'd4;
      end
    end
    n_checks++; if (o.mis !== 1'b0) begin n_fail++; $display("FAIL misalign_flag_clear: got %b expected 0", o.mis); end
`ifdef IFQ_ALIGN_CHK_EN
    n_checks++; if (req_log.size() <= mark || req_log[mark] !== 32'h200) begin n_fail++; $display("FAIL misalign_restart_addr: got %0d new reqs expected first=00000200", req_log.size() - mark); end
`else
    n_checks++; if (req_log.size() <= mark || req_log[mark] !== 32'h100) begin n_fail++; $display("FAIL misalign_forced_addr: got %0d new reqs expected first=00000100", req_log.size() - mark); end
`endif
  endtask

  task automatic test_wrap();
    obs_t o; logic saw_zero = 1'b0;
    lat_min = 1; lat_max = 2; rdy_pct = 100;
    apply_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFF8, o);
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, '0, o);
      if (o.pop) begin
        if (o.pc === 32'h0) saw_zero = 1'b1;
        n_checks++; if (o.pc !== exp_pc || o.instr !== instr_of(exp_pc)) begin n_fail++; $display("FAIL wrap_stream: got pc=%h instr=%h expected pc=%h instr=%h", o.pc, o.instr, exp_pc, instr_of(exp_pc)); end
        exp_pc += 32'd4;
      end
    end
    n_checks++; if (saw_zero !== 1'b1) begin n_fail++; $display("FAIL wrap_zero: got no pc 0 after wrap expected one"); end
  endtask

  task automatic test_random();
    obs_t o, p; logic redir, rdy, p_redir; logic [31:0] tgt; int npops = 0;
    lat_min = 1; lat_max = 4; rdy_pct = 70;
    apply_reset();
    p = '0; p_redir = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rdy   = ($urandom_range(3, 0) != 0);
      redir = ($urandom_range(39, 0) == 0);
      case ($urandom_range(3, 0))
        0:       tgt = 32'hFFFF_FFF0;
        1:       tgt = 32'h0000_0000;
        default: tgt = $urandom & 32'hFFFF_FFFC;
      endcase
      step(rdy, redir, tgt, o);
      if (redir) begin
        n_checks++; if (o.ov !== 1'b0 || o.rv !== 1'b0) begin n_fail++; $display("FAIL rand_redirect_cycle: got ov=%b rv=%b expected 0 0", o.ov, o.rv); end
        exp_pc = tgt;
      end else begin
        if (o.pop) begin
          npops++;
          n_checks++; if (o.pc !== exp_pc || o.instr !== instr_of(exp_pc)) begin n_fail++; $display("FAIL rand_stream: got pc=%h instr=%h expected pc=%h instr=%h", o.pc, o.instr, exp_pc, instr_of(exp_pc)); end
          exp_pc += 32'd4;
        end
        if (p.rv && !p.rrdy && !p_redir) begin
          n_checks++; if (o.rv !== 1'b1 || o.raddr !== p.raddr) begin n_fail++; $display("FAIL rand_req_hold: got rv=%b addr=%h expected rv=1 addr=%h", o.rv, o.raddr, p.raddr); end
        end
      end
      p       = o;
      p_redir = redir;
    end
    n_checks++; if (npops < 200) begin n_fail++; $display("FAIL rand_throughput: got %0d pops expected >=200", npops); end
  endtask

  initial begin
    reset              = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    exp_pc             = RESET_PC;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_reset_mid();
    test_misalign();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
